// File: rtl/y86_seq_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | y86_seq_param: parametrised multicycle y86-subset core with a           |
// | ready-handshaked memory bus. Optional jz decode via Y86_SEQ_JZ_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module y86_seq_param #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_IP = '0,
  parameter int unsigned      BASE_REG = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] bus_A,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_RE,
  output logic             bus_WE,
  input  logic             bus_ready,
  output logic [7:0]       current_opcode,
  output logic             halted,
  output logic             illegal
);

  localparam logic [7:0] C_OP_LOAD = 8'h8B;
  localparam logic [7:0] C_OP_MOVST = 8'h89;
  localparam logic [7:0] C_OP_ADD  = 8'h01;
  localparam logic [7:0] C_OP_SUB  = 8'h29;
  localparam logic [7:0] C_OP_JNEZ = 8'h75;
  localparam logic [7:0] C_OP_HALT = 8'hF4;
  localparam logic [2:0] C_BASE    = BASE_REG[2:0];

  typedef enum logic [5:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_MEM    = 6'b001000,
    S_WB     = 6'b010000,
    S_STOP   = 6'b100000
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_ip;
  logic [WIDTH-1:0] r_ir;
  logic             r_zf;
  logic             r_illegal;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_mar;
  logic [WIDTH-1:0] r_mdrw;
  logic [WIDTH-1:0] r_mdrr;
  logic [WIDTH-1:0] r_regs [8];

  // Instruction fields
  logic [7:0]       w_op;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs;
  logic [1:0]       w_mod;
  logic [WIDTH-1:0] w_disp;
  logic [WIDTH-1:0] w_rel;
  logic             w_unused_ir_hi;

  assign w_op           = r_ir[7:0];
  assign w_rd           = r_ir[10:8];
  assign w_rs           = r_ir[13:11];
  assign w_mod          = r_ir[15:14];
  assign w_disp         = {{(WIDTH-8){r_ir[23]}}, r_ir[23:16]};
  assign w_rel          = {{(WIDTH-8){r_ir[15]}}, r_ir[15:8]};
  assign w_unused_ir_hi = ^r_ir[WIDTH-1:24];

  logic w_is_load, w_is_store, w_is_move, w_is_add, w_is_sub;
  logic w_is_jnez, w_is_jz, w_is_halt, w_is_branch, w_is_mem, w_is_illegal;
  logic w_taken;

  assign w_is_load  = (w_op == C_OP_LOAD);
  assign w_is_store = (w_op == C_OP_MOVST) && (w_mod == 2'd1);
  assign w_is_move  = (w_op == C_OP_MOVST) && (w_mod == 2'd3);
  assign w_is_add   = (w_op == C_OP_ADD);
  assign w_is_sub   = (w_op == C_OP_SUB);
  assign w_is_jnez  = (w_op == C_OP_JNEZ);
  assign w_is_halt  = (w_op == C_OP_HALT);

`ifdef Y86_SEQ_JZ_EN
  localparam logic [7:0] C_OP_JZ = 8'h74;
  assign w_is_jz = (w_op == C_OP_JZ);
`else
  assign w_is_jz = 1'b0;
`endif

  assign w_is_branch  = w_is_jnez | w_is_jz;
  assign w_is_mem     = w_is_load | w_is_store;
  assign w_is_illegal = ~(w_is_mem | w_is_move | w_is_add | w_is_sub |
                          w_is_branch | w_is_halt);
  // Branch condition reads ZF as left by the previous instruction
  assign w_taken      = (w_is_jnez & ~r_zf) | (w_is_jz & r_zf);

  logic [WIDTH-1:0] w_len;
  logic [WIDTH-1:0] w_ip_next;
  logic [2:0]       w_aad;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH-1:0] w_alu;

  always_comb begin
    w_len = WIDTH'(1);
    if (w_is_mem)
      w_len = WIDTH'(3);
    else if (w_is_add || w_is_sub || w_is_move || w_is_branch)
      w_len = WIDTH'(2);
  end

  assign w_ip_next = r_ip + w_len + (w_taken ? w_rel : '0);
  assign w_aad     = w_is_mem ? C_BASE : w_rd;
  assign w_op2     = w_is_mem ? w_disp : (w_is_sub ? ~r_b : r_b);
  assign w_alu     = r_a + w_op2 + WIDTH'(w_is_sub);

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_FETCH;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    bus_RE       = 1'b0;
    bus_WE       = 1'b0;
    bus_A        = '0;
    case (r_state)
      S_FETCH: begin
        bus_RE = 1'b1;
        bus_A  = r_ip;
        if (bus_ready)
          w_state_next = S_DECODE;
      end
      S_DECODE: w_state_next = (w_is_halt || w_is_illegal) ? S_STOP : S_EXEC;
      S_EXEC:   w_state_next = S_MEM;
      S_MEM: begin
        bus_RE = w_is_load;
        bus_WE = w_is_store;
        if (w_is_mem)
          bus_A = r_mar;
        if (!w_is_mem || bus_ready)
          w_state_next = S_WB;
      end
      S_WB:     w_state_next = S_FETCH;
      S_STOP:   w_state_next = S_STOP;
      default:  w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ip      <= RESET_IP;
      r_ir      <= '0;
      r_zf      <= 1'b0;
      r_illegal <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_mar     <= '0;
      r_mdrw    <= '0;
      r_mdrr    <= '0;
      for (int i = 0; i < 8; i++)
        r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus_ready)
            r_ir <= bus_in;
        end
        S_DECODE: begin
          r_a <= r_regs[w_aad];
          r_b <= r_regs[w_rs];
          if (w_is_halt || w_is_illegal)
            r_illegal <= w_is_illegal;
          else
            r_ip <= w_ip_next;
        end
        S_EXEC: begin
          r_mar  <= w_alu;
          r_mdrw <= r_b;
          r_c    <= w_is_move ? r_b : w_alu;
          if (w_is_add || w_is_sub)
            r_zf <= (w_alu == '0);
        end
        S_MEM: begin
          if (w_is_load && bus_ready)
            r_mdrr <= bus_in;
        end
        S_WB: begin
          if (w_is_load)
            r_regs[w_rs] <= r_mdrr;
          else if (w_is_add || w_is_sub || w_is_move)
            r_regs[w_rd] <= r_c;
        end
        default: ;
      endcase
    end
  end

  assign bus_out        = r_mdrw;
  assign current_opcode = r_ir[7:0];
  assign halted         = (r_state == S_STOP);
  assign illegal        = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_y86_seq_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_y86_seq_param: directed bench for y86_seq_param (WIDTH 32 and 24).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_y86_seq_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst24_n;
  logic [31:0] bus_A, bus_in, bus_out;
  logic        bus_RE, bus_WE, bus_ready;
  logic [7:0]  current_opcode;
  logic        halted, illegal;
  logic [23:0] bus_A24, bus_in24, bus_out24;
  logic        bus_RE24, bus_WE24;
  logic        bus_ready24;
  logic [7:0]  current_opcode24;
  logic        halted24, illegal24;

  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;
  int data_waits = 0;
  int wcnt = 0;
  int n_we104 = 0, n_we104_bad = 0, n_wr104 = 0, n_wr120 = 0, n_sub_fetch = 0;

  logic [7:0] rom   [0:259];
  logic [7:0] ram   [0:259];
  logic [7:0] rom24 [0:259];

  always #5 clk = ~clk;

  y86_seq_param #(.WIDTH(32), .RESET_IP(32'h10), .BASE_REG(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus_A(bus_A), .bus_in(bus_in), .bus_out(bus_out),
    .bus_RE(bus_RE), .bus_WE(bus_WE), .bus_ready(bus_ready),
    .current_opcode(current_opcode), .halted(halted), .illegal(illegal));

  y86_seq_param #(.WIDTH(24), .RESET_IP(24'h0), .BASE_REG(6)) dut24 (
    .clk(clk), .rst_n(rst24_n), .bus_A(bus_A24), .bus_in(bus_in24), .bus_out(bus_out24),
    .bus_RE(bus_RE24), .bus_WE(bus_WE24), .bus_ready(bus_ready24),
    .current_opcode(current_opcode24), .halted(halted24), .illegal(illegal24));

  // Memory model: program/constant bytes below 0x100, wait-stated RAM at 0x100..0x1FF
  assign bus_ready   = (bus_A < 32'h100) ? 1'b1 : (wcnt >= data_waits);
  assign bus_ready24 = 1'b1;

  always_comb begin
    int a;
    a = int'(bus_A[7:0]);
    bus_in = '0;
    if (bus_A < 32'h100)
      bus_in = {rom[a+3], rom[a+2], rom[a+1], rom[a]};
    else if (bus_A < 32'h200)
      bus_in = {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  end

  always_comb begin
    int a;
    a = int'(bus_A24[7:0]);
    bus_in24 = '0;
    if (bus_A24 < 24'h100)
      bus_in24 = {rom24[a+2], rom24[a+1], rom24[a]};
  end

  always @(posedge clk) begin
    if (!(bus_RE || bus_WE) || bus_ready) wcnt <= 0;
    else                                  wcnt <= wcnt + 1;
    if (bus_WE && bus_ready && bus_A >= 32'h100 && bus_A < 32'h1FC) begin
      ram[int'(bus_A[7:0])]   <= bus_out[7:0];
      ram[int'(bus_A[7:0])+1] <= bus_out[15:8];
      ram[int'(bus_A[7:0])+2] <= bus_out[23:16];
      ram[int'(bus_A[7:0])+3] <= bus_out[31:24];
      if (bus_A == 32'h104) n_wr104 <= n_wr104 + 1;
      if (bus_A == 32'h120) n_wr120 <= n_wr120 + 1;
    end
  end

  always @(negedge clk) begin
    if (bus_WE && bus_A == 32'h104) begin
      n_we104 <= n_we104 + 1;
      if (bus_out !== 32'hA5C31E27) n_we104_bad <= n_we104_bad + 1;
    end
    if (phase == 2 && bus_RE && bus_A == 32'h16) n_sub_fetch <= n_sub_fetch + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int a, input int n, input logic [31:0] v);
    for (int k = 0; k < n; k++) rom[a+k] = v[8*k +: 8];
  endtask

  task automatic put24(input int a, input int n, input logic [31:0] v);
    for (int k = 0; k < n; k++) rom24[a+k] = v[8*k +: 8];
  endtask

  task automatic start_phase(input int p, input int waits);
    rst_n = 1'b0;
    phase = p;
    data_waits = waits;
    for (int k = 0; k < 260; k++) rom[k] = 8'h00;
    tick();
    tick();
  endtask

  task automatic run_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    rst24_n = 1'b0;
    for (int k = 0; k < 260; k++) begin
      ram[k]   = 8'h00;
      rom24[k] = 8'h00;
    end

    // Phase 1: reset state, then store/load through R6 with 3 wait states per MEM
    start_phase(1, 3);
    put(16'h10, 3, 32'h44568B);   // load R2,[R6+0x44]
    put(16'h13, 3, 32'h40768B);   // load R6,[R6+0x40]
    put(16'h16, 3, 32'h045689);   // store R2,[R6+4]
    put(16'h19, 3, 32'h044E8B);   // load R1,[R6+4]
    put(16'h1C, 3, 32'h084E89);   // store R1,[R6+8]
    put(16'h1F, 1, 32'hF4);       // halt
    put(16'h40, 4, 32'h00000100);
    put(16'h44, 4, 32'hA5C31E27);
    check("rst_bus_A",  bus_A, 32'h10);
    check("rst_bus_RE", bus_RE, 1'b1);
    check("rst_bus_WE", bus_WE, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_opcode", current_opcode, 8'h00);
    check("rst_bus_out", bus_out, 32'h0);
    rst_n = 1'b1;
    tick();
    check("ir_loaded", current_opcode, 8'h8B);
    check("decode_no_read", bus_RE, 1'b0);
    run_halt(300);
    check("p1_halted", halted, 1'b1);
    check("p1_illegal", illegal, 1'b0);
    check("p1_we_cycles", n_we104, 4);
    check("p1_we_stable", n_we104_bad, 0);
    check("p1_writes_104", n_wr104, 1);
    check("p1_ram_104", {ram[7], ram[6], ram[5], ram[4]}, 32'hA5C31E27);
    check("p1_ram_108_R1", {ram[11], ram[10], ram[9], ram[8]}, 32'hA5C31E27);
    check("p1_R1", dut.r_regs[1], 32'hA5C31E27);
    check("p1_R6", dut.r_regs[6], 32'h100);
    check("p1_ip", dut.r_ip, 32'h1F);
    tick();
    check("stop_bus_A", bus_A, 32'h0);
    check("stop_bus_RE", bus_RE, 1'b0);

    // Phase 2: sub/jnez loop, R0=3 R1=1
    start_phase(2, 0);
    put(16'h10, 3, 32'h40468B);   // load R0,[0x40]
    put(16'h13, 3, 32'h444E8B);   // load R1,[0x44]
    put(16'h16, 2, 32'hC829);     // sub R0,R1
    put(16'h18, 2, 32'hFC75);     // jnez -4
    put(16'h1A, 1, 32'hF4);       // halt
    put(16'h40, 4, 32'd3);
    put(16'h44, 4, 32'd1);
    rst_n = 1'b1;
    run_halt(300);
    check("p2_halted", halted, 1'b1);
    check("p2_loop_count", n_sub_fetch, 3);
    check("p2_zf", dut.r_zf, 1'b1);
    check("p2_R0", dut.r_regs[0], 32'h0);
    check("p2_ip", dut.r_ip, 32'h1A);
    check("p2_illegal", illegal, 1'b0);

    // Phase 3: opcode 0x74 after ZF set by sub R0,R0
    start_phase(3, 0);
    put(16'h10, 2, 32'hC029);     // sub R0,R0 -> ZF=1
    put(16'h12, 2, 32'h0274);     // jz +2
    put(16'h14, 2, 32'hFFFF);     // undecoded filler
    put(16'h16, 1, 32'hF4);       // halt
    rst_n = 1'b1;
    run_halt(300);
    check("p3_halted", halted, 1'b1);
`ifdef Y86_SEQ_JZ_EN
    check("p3_illegal", illegal, 1'b0);
    check("p3_ip", dut.r_ip, 32'h16);
`else
    check("p3_illegal", illegal, 1'b1);
    check("p3_ip", dut.r_ip, 32'h12);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("p3_stop_RE", bus_RE, 1'b0);
      check("p3_stop_WE", bus_WE, 1'b0);
    end

    // Phase 4: reset asserted while a store waits in MEM
    start_phase(4, 1000);
    put(16'h10, 3, 32'h445E8B);   // load R3,[0x44]
    put(16'h13, 3, 32'h40768B);   // load R6,[0x40]
    put(16'h16, 3, 32'h207689);   // store R6,[R6+0x20]
    put(16'h40, 4, 32'h00000100);
    put(16'h44, 4, 32'h12345678);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && !bus_WE; i++) tick();
    check("p4_we_reached", bus_WE, 1'b1);
    tick();
    tick();
    check("p4_we_held", bus_WE, 1'b1);
    check("p4_we_addr", bus_A, 32'h120);
    check("p4_we_data", bus_out, 32'h100);
    rst_n = 1'b0;
    tick();
    check("p4_we_dropped", bus_WE, 1'b0);
    check("p4_fetch_RE", bus_RE, 1'b1);
    check("p4_fetch_A", bus_A, 32'h10);
    check("p4_no_write", n_wr120, 0);
    check("p4_zf", dut.r_zf, 1'b0);
    for (int r = 0; r < 8; r++) check("p4_reg_zero", dut.r_regs[r], 32'h0);

    // Phase 5: WIDTH=24 add wrap 0xFFFFFF + 1
    put24(16'h00, 3, 32'h40468B); // load R0,[0x40]
    put24(16'h03, 3, 32'h444E8B); // load R1,[0x44]
    put24(16'h06, 2, 32'hC801);   // add R0,R1
    put24(16'h08, 1, 32'hF4);     // halt
    put24(16'h40, 3, 32'hFFFFFF);
    put24(16'h44, 3, 32'h000001);
    tick();
    check("w24_rst_A", bus_A24, 24'h0);
    rst24_n = 1'b1;
    for (int i = 0; i < 300 && !halted24; i++) tick();
    check("w24_halted", halted24, 1'b1);
    check("w24_illegal", illegal24, 1'b0);
    check("w24_R0_wrap", dut24.r_regs[0], 24'h000000);
    check("w24_R1", dut24.r_regs[1], 24'h000001);
    check("w24_zf", dut24.r_zf, 1'b1);
    check("w24_ip", dut24.r_ip, 24'h08);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
